// File: rtl/repl_policy.sv
// repl_policy: per-set age-based LRU replacement state; define REPL_LOCK_EN to add way locking (lock_mask/all_locked)
module repl_policy #(
  parameter int SET_LOG2 = 4,
  parameter int WAY_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                touch_en,
  input  logic [SET_LOG2-1:0] touch_set,
  input  logic [WAY_LOG2-1:0] touch_way,
  input  logic                replace_en,
  input  logic [SET_LOG2-1:0] replace_set,
  input  logic [SET_LOG2-1:0] query_set,
  output logic [WAY_LOG2-1:0] victim
`ifdef REPL_LOCK_EN
  ,
  input  logic [2**WAY_LOG2-1:0] lock_mask,
  output logic                   all_locked
`endif
);
  localparam int SETS = 2 ** SET_LOG2;
  localparam int WAYS = 2 ** WAY_LOG2;
  typedef logic [WAYS-1:0][WAY_LOG2-1:0] row_t;
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [SET_LOG2-1:0] cnt;
  row_t age [SETS];
  logic [WAYS-1:0] mask;
  logic rep_ok, touch_ok;
  logic [WAY_LOG2-1:0] rep_way;
`ifdef REPL_LOCK_EN
  assign mask = lock_mask;
  assign all_locked = ready & (&lock_mask);
`else
  assign mask = '0;
`endif
  // lowest-age unlocked way; falls back to the age-0 way when everything is locked
  function automatic logic [WAY_LOG2-1:0] pick(row_t r, logic [WAYS-1:0] m);
    logic [WAY_LOG2-1:0] v, best;
    logic found;
    v = '0;
    best = '0;
    found = 1'b0;
    for (int i = 0; i < WAYS; i++) if (r[i] == '0) v = WAY_LOG2'(i);
    for (int i = 0; i < WAYS; i++)
      if (!m[i] && (!found || r[i] < best)) begin
        v = WAY_LOG2'(i);
        best = r[i];
        found = 1'b1;
      end
    return v;
  endfunction
  function automatic row_t access(row_t r, logic [WAY_LOG2-1:0] w);
    row_t n;
    for (int i = 0; i < WAYS; i++)
      n[i] = (WAY_LOG2'(i) == w) ? WAY_LOG2'(WAYS - 1) : (r[i] > r[w]) ? r[i] - 1'b1 : r[i];
    return n;
  endfunction
  assign rep_way = pick(age[replace_set], mask);
  assign rep_ok = ready & replace_en & ~(&mask);
  assign touch_ok = ready & touch_en & ~(replace_en & (replace_set == touch_set));
  assign victim = ready ? pick(age[query_set], mask) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      ready <= 1'b0;
    end else if (state == INIT) begin
      for (int w = 0; w < WAYS; w++) age[cnt][w] <= WAY_LOG2'(w);
      cnt <= cnt + 1'b1;
      if (&cnt) state <= RUN;
    end else begin
      ready <= 1'b1;
      if (rep_ok) age[replace_set] <= access(age[replace_set], rep_way);
      if (touch_ok) age[touch_set] <= access(age[touch_set], touch_way);
    end
  end
endmodule

// File: tb/tb_repl_policy.sv
// tb_repl_policy: randomized check of repl_policy against an ordered-list LRU model
module tb_repl_policy;
  logic clk = 1'b0;
  logic reset, ready, touch_en, replace_en;
  logic [3:0] touch_set, replace_set, query_set;
  logic [1:0] touch_way, victim;
  logic [3:0] lock_mask;
  logic all_locked;
  int checks = 0;
  int errors = 0;
  int ord [16][4];

  repl_policy dut (
    .clk(clk), .reset(reset), .ready(ready),
    .touch_en(touch_en), .touch_set(touch_set), .touch_way(touch_way),
    .replace_en(replace_en), .replace_set(replace_set),
    .query_set(query_set), .victim(victim)
`ifdef REPL_LOCK_EN
    , .lock_mask(lock_mask), .all_locked(all_locked)
`endif
  );

  always #5 clk = ~clk;

  // model: each set is a list of ways ordered LRU first, MRU last
  function automatic void model_init();
    for (int s = 0; s < 16; s++) for (int i = 0; i < 4; i++) ord[s][i] = i;
  endfunction

  function automatic void model_access(int s, int w);
    int p = 0;
    for (int i = 0; i < 4; i++) if (ord[s][i] == w) p = i;
    for (int i = p; i < 3; i++) ord[s][i] = ord[s][i+1];
    ord[s][3] = w;
  endfunction

  function automatic int model_victim(int s, logic [3:0] m);
    for (int i = 0; i < 4; i++) if (!m[ord[s][i]]) return ord[s][i];
    return ord[s][0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    touch_en = 0;
    replace_en = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    model_init();
    for (int c = 1; c <= 16; c++) begin
      query_set = 4'(c - 1);
      touch_en = 1;
      touch_set = 4'(c - 1);
      touch_way = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL init_ready cycle %0d got %b want 0", c, ready); end
      checks++;
      if (victim !== 2'd0) begin errors++; $display("FAIL init_victim cycle %0d got %0d want 0", c, victim); end
    end
    idle();
    tick();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_cycle17 got %b want 1", ready); end
    for (int s = 0; s < 16; s++) begin
      query_set = 4'(s);
      #1;
      checks++;
      if (victim !== 2'(ord[s][0])) begin errors++; $display("FAIL reset_victim set %0d got %0d want %0d", s, victim, ord[s][0]); end
    end
  endtask

  task automatic test_touch();
    for (int w = 0; w < 3; w++) begin
      touch_en = 1;
      touch_set = 4'd3;
      touch_way = 2'(w);
      tick();
      model_access(3, w);
    end
    idle();
    query_set = 4'd3;
    #1;
    checks++;
    if (victim !== 2'(ord[3][0]) || victim !== 2'd3) begin errors++; $display("FAIL touch_set3 got %0d want %0d", victim, ord[3][0]); end
    query_set = 4'd4;
    #1;
    checks++;
    if (victim !== 2'd0) begin errors++; $display("FAIL touch_set4 got %0d want 0", victim); end
  endtask

  task automatic test_replace();
    int want;
    for (int k = 0; k < 5; k++) begin
      query_set = 4'd5;
      #1;
      want = ord[5][0];
      checks++;
      if (victim !== 2'(want)) begin errors++; $display("FAIL replace_seq step %0d got %0d want %0d", k, victim, want); end
      replace_en = 1;
      replace_set = 4'd5;
      tick();
      model_access(5, want);
      idle();
    end
  endtask

  task automatic test_collision();
    touch_en = 1;
    touch_set = 4'd2;
    touch_way = 2'd0;
    replace_en = 1;
    replace_set = 4'd2;
    tick();
    model_access(2, ord[2][0]);
    idle();
    query_set = 4'd2;
    #1;
    checks++;
    if (victim !== 2'(ord[2][0]) || victim !== 2'd1) begin errors++; $display("FAIL collision_way0 got %0d want %0d", victim, ord[2][0]); end
    touch_en = 1;
    touch_way = 2'd2;
    replace_en = 1;
    tick();
    model_access(2, ord[2][0]);
    idle();
    #1;
    checks++;
    if (victim !== 2'(ord[2][0])) begin errors++; $display("FAIL collision_drop got %0d want %0d", victim, ord[2][0]); end
  endtask

  task automatic test_random();
    int rs, ts, tw;
    for (int c = 0; c < 400; c++) begin
      touch_en = 1'($urandom_range(0, 1));
      replace_en = 1'($urandom_range(0, 1));
      ts = $urandom_range(0, 3);
      rs = $urandom_range(0, 3);
      tw = $urandom_range(0, 3);
      touch_set = 4'(ts);
      replace_set = 4'(rs);
      touch_way = 2'(tw);
      query_set = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (victim !== 2'(ord[query_set][0])) begin errors++; $display("FAIL random cycle %0d set %0d got %0d want %0d", c, query_set, victim, ord[query_set][0]); end
      tick();
      if (replace_en) model_access(rs, ord[rs][0]);
      if (touch_en && !(replace_en && rs == ts)) model_access(ts, tw);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    reset = 1;
    tick();
    reset = 0;
    for (int c = 1; c <= 7; c++) begin
      touch_en = 1;
      touch_set = 4'($urandom_range(0, 15));
      touch_way = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    model_init();
    for (int c = 1; c <= 16; c++) begin
      touch_en = 1;
      replace_en = 1;
      touch_set = 4'($urandom_range(0, 15));
      replace_set = 4'($urandom_range(0, 15));
      touch_way = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready cycle %0d got %b want 0", c, ready); end
    end
    idle();
    tick();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready17 got %b want 1", ready); end
    for (int s = 0; s < 16; s++) begin
      query_set = 4'(s);
      #1;
      checks++;
      if (victim !== 2'(ord[s][0])) begin errors++; $display("FAIL midreset_victim set %0d got %0d want %0d", s, victim, ord[s][0]); end
    end
  endtask

`ifdef REPL_LOCK_EN
  task automatic test_lock();
    int want;
    lock_mask = 4'b0011;
    query_set = 4'd7;
    #1;
    want = model_victim(7, lock_mask);
    checks++;
    if (victim !== 2'(want) || victim !== 2'd2) begin errors++; $display("FAIL lock_0011 got %0d want %0d", victim, want); end
    replace_en = 1;
    replace_set = 4'd7;
    tick();
    model_access(7, want);
    idle();
    lock_mask = 4'b1111;
    #1;
    checks++;
    if (all_locked !== 1'b1) begin errors++; $display("FAIL all_locked got %b want 1", all_locked); end
    checks++;
    if (victim !== 2'(ord[7][0])) begin errors++; $display("FAIL lock_1111_victim got %0d want %0d", victim, ord[7][0]); end
    replace_en = 1;
    tick();
    idle();
    lock_mask = 4'b0011;
    #1;
    want = model_victim(7, lock_mask);
    checks++;
    if (victim !== 2'(want)) begin errors++; $display("FAIL lock_replace_ignored got %0d want %0d", victim, want); end
    lock_mask = 4'b0000;
    #1;
    checks++;
    if (all_locked !== 1'b0) begin errors++; $display("FAIL all_locked_clear got %b want 0", all_locked); end
  endtask
`endif

  initial begin
    reset = 1;
    touch_en = 0;
    replace_en = 0;
    touch_set = 0;
    touch_way = 0;
    replace_set = 0;
    query_set = 0;
    lock_mask = 0;
    test_reset();
    test_touch();
    test_replace();
    test_collision();
    test_random();
    test_reset_mid();
`ifdef REPL_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
